cache_fill_ctrl: RTL
====================

Name: cache_fill_ctrl

Overview:
- Sequences a cache line fill on a miss.
- Issues WORDS single-word reads to the memory port using an address/grant handshake with in-order read data.
- Packs the returned words into one line and presents it to the cache array with a valid/ready handshake.
- Sits between the cache miss logic and the 32-bit memory interface. It is the controller that replaces free-running shift-in of fill data.

Parameters:
- ADDR_W, 32, byte address width.
- WORD_W, 32, memory data word width.
- WORDS, 8, words per line. Must be a power of two. Line width LINE_W = WORDS*WORD_W = 256.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- miss_req, input, 1, fill request; held by the requester until miss_ack.
- miss_addr, input, ADDR_W, byte address of the missing access.
- miss_ack, output, 1, one-cycle pulse: request accepted.
- mem_req, output, 1, word read address valid.
- mem_addr, output, ADDR_W, word-aligned read address.
- mem_gnt, input, 1, address accepted in any cycle where mem_req && mem_gnt.
- mem_rvalid, input, 1, read data valid; data returns in issue order.
- mem_rdata, input, WORD_W, read data.
- line_valid, output, 1, assembled line available.
- line_data, output, LINE_W, assembled line; word i occupies bits [WORD_W*i +: WORD_W].
- line_addr, output, ADDR_W, line-aligned address of line_data.
- line_ready, input, 1, consumer accepts the line when line_valid && line_ready.
- busy, output, 1, high in any state other than IDLE.
- protocol_err, output, 1, sticky error flag.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; counters = 0.
  - miss_ack, mem_req, line_valid, busy, protocol_err = 0.
  - mem_addr, line_addr, line_data = 0.
  - Deassertion takes effect at the next rising edge.
- States: IDLE, FILL, PRESENT. busy = (state != IDLE).
- IDLE, on an edge with miss_req=1:
  - Capture base = miss_addr with the low log2(WORDS*WORD_W/8) bits cleared (low 5 bits for defaults).
  - Set issue_cnt = recv_cnt = 0.
  - Go to FILL.
  - Pulse miss_ack for exactly the following cycle.
- miss_req while busy is ignored: no ack, no capture. The requester keeps it high; it is accepted on the first IDLE edge.
- FILL, address issue:
  - mem_req = (issue_cnt < WORDS).
  - mem_addr = base + issue_cnt*(WORD_W/8).
  - On an edge with mem_req && mem_gnt, issue_cnt increments.
  - mem_addr must stay stable while mem_req=1 && mem_gnt=0.
  - Back-to-back issue is allowed: one address per cycle with no required gap.
- FILL, data return:
  - On an edge with mem_rvalid=1 and recv_cnt < issue_cnt, write mem_rdata into word slot recv_cnt and increment recv_cnt.
  - A grant and an rvalid in the same cycle are both processed.
  - Data may arrive with any latency ≥1 cycle after its grant.
- FILL exit: the edge that makes recv_cnt = WORDS moves to PRESENT, with line_valid=1 and line_addr=base from the next cycle.
- Minimum latency, with gnt held high and data one cycle after grant: the miss_req acceptance edge to line_valid high is 9 edges.
- PRESENT:
  - line_valid, line_data and line_addr are held stable until the edge with line_ready=1.
  - On that edge go to IDLE; line_valid=0 next cycle.
  - line_data keeps its last value in IDLE.
  - A new miss is accepted no earlier than the edge after the handshake.
- protocol_err is set, and never cleared except by reset, on either of:
  - mem_rvalid=1 when recv_cnt >= issue_cnt (no outstanding read), or in IDLE/PRESENT. The data is discarded and the counters are unchanged.
- Counters are log2(WORDS)+1 bits wide. issue_cnt saturates at WORDS (no wrap). Address arithmetic is modulo 2^ADDR_W.
- Reset mid-FILL drops all outstanding reads. Stale rvalids arriving after reset flag protocol_err.

Test Plan:
- Basic fill: miss_addr=0x0000_1234, gnt always 1, rdata = 0xA0+i one cycle after each grant.
  - Expected: mem_addr sequence 0x1220..0x123C.
  - line_addr=0x1220, line_data word i = 0xA0+i.
  - line_valid rises 9 edges after acceptance; miss_ack is a single pulse.
- Grant stalls: gnt low 3 cycles on word 2, random rvalid delays 1–5.
  - Expected: mem_addr held at base+8 during the stall, word order preserved, protocol_err=0.
- Backpressure: line_ready held low 10 cycles after line_valid.
  - Expected: line_data stable, busy=1, a pending miss_req not acked until the edge after line_ready.
- Back-to-back misses at 0x40 and 0x80 with miss_req held high.
  - Expected: second miss_ack one cycle after the first line handshake; second line_addr=0x80.
- Reset mid-fill: rst_n low after 4 grants.
  - Expected: all outputs 0 immediately (async). After release, a fresh fill at 0x200 completes correctly.
- Spurious rvalid in IDLE, and an extra rvalid beyond the grants.
  - Expected: protocol_err=1 and sticky, line contents unchanged, FSM unaffected.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl
//   Fills one cache line after a miss. Issues WORDS single-word reads on an
//   address/grant memory port, collects the in-order read data into word
//   slots, then offers the packed line to the cache array on a valid/ready
//   handshake.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   miss_req, miss_addr        fill request (held until miss_ack) + byte addr
//   miss_ack                   one-cycle accept pulse
//   mem_req, mem_addr, mem_gnt word read address channel
//   mem_rvalid, mem_rdata      in-order read data return
//   line_valid, line_data,
//   line_addr, line_ready      assembled line to the cache array
//   busy                       controller not idle
//   protocol_err               sticky: read data with no read outstanding

// One word slot of the line buffer; written when its index is next to fill.
module cfc_word_slot #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= '0;
      else if (wr) q <= d;
   end
endmodule

module cache_fill_ctrl #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int WORDS  = 8,
   localparam int LINE_W = WORDS * WORD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_req,
   input  logic [ADDR_W-1:0] miss_addr,
   output logic              miss_ack,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              line_valid,
   output logic [LINE_W-1:0] line_data,
   output logic [ADDR_W-1:0] line_addr,
   input  logic              line_ready,
   output logic              busy,
   output logic              protocol_err
);
   localparam int CNT_W = $clog2(WORDS) + 1;
   localparam int OFF_W = $clog2(WORDS * WORD_W / 8);
   localparam int BPW   = WORD_W / 8;

   typedef enum logic [1:0] {IDLE, FILL, PRESENT} state_t;

   state_t                        state, state_nxt;
   logic [CNT_W-1:0]              issue_cnt, recv_cnt;
   logic [ADDR_W-1:0]             base;
   logic [WORDS-1:0][WORD_W-1:0]  words;
   logic                          accept, issue, take, err_hit, last_word;

   assign last_word = (recv_cnt == CNT_W'(WORDS - 1));

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      issue     = 1'b0;
      take      = 1'b0;
      err_hit   = 1'b0;
      case (state)
         IDLE: begin
            accept  = miss_req;
            err_hit = mem_rvalid;
            if (miss_req) state_nxt = FILL;
         end
         FILL: begin
            issue   = mem_req && mem_gnt;
            // Only data for a read granted on an earlier edge is accepted.
            take    = mem_rvalid && (recv_cnt < issue_cnt);
            err_hit = mem_rvalid && !take;
            if (take && last_word) state_nxt = PRESENT;
         end
         PRESENT: begin
            err_hit = mem_rvalid;
            if (line_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address is derived from the counter so it holds by itself while ungranted.
   assign mem_req    = (state == FILL) && (issue_cnt < CNT_W'(WORDS));
   assign mem_addr   = base + (ADDR_W'(issue_cnt) * ADDR_W'(BPW));
   assign line_valid = (state == PRESENT);
   assign busy       = (state != IDLE);
   assign line_data  = words;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         miss_ack     <= 1'b0;
         issue_cnt    <= '0;
         recv_cnt     <= '0;
         base         <= '0;
         line_addr    <= '0;
         protocol_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         miss_ack <= accept;
         if (accept) begin
            base      <= {miss_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            issue_cnt <= '0;
            recv_cnt  <= '0;
         end
         if (issue) issue_cnt <= issue_cnt + 1'b1;
         if (take)  recv_cnt  <= recv_cnt + 1'b1;
         if (take && last_word) line_addr <= base;
         if (err_hit) protocol_err <= 1'b1;
      end
   end

   for (genvar i = 0; i < WORDS; i++) begin : g_slot
      cfc_word_slot #(.WORD_W(WORD_W)) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .wr    (take && (recv_cnt == CNT_W'(i))),
         .d     (mem_rdata),
         .q     (words[i])
      );
   end
endmodule
